// File: rtl/coincidence_counter_pkg.sv
// Shared types and default widths for the photon coincidence
// counter and its readout stage.
package coincidence_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int CNT_W_DEF  = 32;
  localparam int GATE_W_DEF = 32;
  localparam int WIN_W_DEF  = 8;

endpackage

// File: rtl/window_edge_timer.sv
// Per-channel rising-edge detector and coincidence window timer.
// Arbitration decides load/clear; this block only keeps the time.
module window_edge_timer
  import coincidence_counter_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse,
  input  logic             load,
  input  logic             clear,
  input  logic [WIN_W-1:0] window,
  output logic             rise,
  output logic             win_open
);

  logic             prev;
  logic [WIN_W-1:0] win;

  assign rise     = pulse & ~prev;
  assign win_open = (win != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
      win  <= '0;
    end else begin
      prev <= pulse;
      if (clear)
        win <= '0;
      else if (load)
        win <= window;
      else if (win_open)
        win <= win - 1'b1;
    end
  end

endmodule

// File: rtl/coincidence_counter.sv
// Singles and A/B coincidence counter over back-to-back gate
// periods, with latched results on a valid/ready port.
module coincidence_counter
  import coincidence_counter_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int GATE_W = GATE_W_DEF,
  parameter int WIN_W  = WIN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [WIN_W-1:0]  window,
  input  logic              pulse_a,
  input  logic              pulse_b,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b,
  output logic [CNT_W-1:0]  cnt_ab,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              busy
);

  state_t            state;
  logic [GATE_W-1:0] gate_cnt;
  logic [GATE_W-1:0] gate_last;
  logic [WIN_W-1:0]  win_len;
  logic [CNT_W-1:0]  acc_a, acc_b, acc_ab;
  logic [CNT_W-1:0]  nxt_a, nxt_b, nxt_ab;
  logic              rise_a, rise_b;
  logic              open_a, open_b;
  logic              run, period_end, coinc;
  logic              load_a, load_b;
  logic              clr_a, clr_b;

  assign run        = (state == RUN) & enable;
  assign period_end = run & (gate_cnt == gate_last);

  window_edge_timer #(.WIN_W(WIN_W)) u_tim_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse    (pulse_a),
    .load     (load_a),
    .clear    (clr_a),
    .window   (win_len),
    .rise     (rise_a),
    .win_open (open_a)
  );

  window_edge_timer #(.WIN_W(WIN_W)) u_tim_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse    (pulse_b),
    .load     (load_b),
    .clear    (clr_b),
    .window   (win_len),
    .rise     (rise_b),
    .win_open (open_b)
  );

  // An edge either closes the partner's open window or opens its own.
  always_comb begin
    coinc  = 1'b0;
    load_a = 1'b0;
    load_b = 1'b0;
    clr_a  = ~run | period_end;
    clr_b  = ~run | period_end;
    unique case (1'b1)
      rise_a & rise_b: begin
        coinc = 1'b1;
        clr_a = 1'b1;
        clr_b = 1'b1;
      end
      rise_b & ~rise_a & open_a: begin
        coinc = 1'b1;
        clr_a = 1'b1;
      end
      rise_a & ~rise_b & open_b: begin
        coinc = 1'b1;
        clr_b = 1'b1;
      end
      rise_a & ~rise_b & ~open_b: load_a = 1'b1;
      rise_b & ~rise_a & ~open_a: load_b = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    nxt_a  = acc_a;
    nxt_b  = acc_b;
    nxt_ab = acc_ab;
    if (rise_a && acc_a != '1)
      nxt_a = acc_a + 1'b1;
    if (rise_b && acc_b != '1)
      nxt_b = acc_b + 1'b1;
    if (coinc && acc_ab != '1)
      nxt_ab = acc_ab + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gate_cnt  <= '0;
      gate_last <= '0;
      win_len   <= '0;
      acc_a     <= '0;
      acc_b     <= '0;
      acc_ab    <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      cnt_ab    <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state     <= RUN;
            busy      <= 1'b1;
            gate_last <= (gate_len == '0) ?
                         '0 : gate_len - 1'b1;
            win_len   <= window;
            overrun   <= 1'b0;
            gate_cnt  <= '0;
            acc_a     <= '0;
            acc_b     <= '0;
            acc_ab    <= '0;
          end
        end
        RUN: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (period_end) begin
            gate_cnt <= '0;
            acc_a    <= '0;
            acc_b    <= '0;
            acc_ab   <= '0;
            if (!out_valid || out_ready) begin
              cnt_a     <= nxt_a;
              cnt_b     <= nxt_b;
              cnt_ab    <= nxt_ab;
              out_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
            acc_a    <= nxt_a;
            acc_b    <= nxt_b;
            acc_ab   <= nxt_ab;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coincidence_counter.sv
// Scoreboard bench: event-time reference model predicts results,
// a negedge monitor pops and compares on each handshake.
module tb_coincidence_counter;

  localparam int GW = 32;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          pulse_a = 1'b0;
  logic          pulse_b = 1'b0;
  logic          out_ready = 1'b0;
  logic [GW-1:0] gate_len = '0;
  logic [WW-1:0] window = '0;

  logic [31:0] cnt_a, cnt_b, cnt_ab;
  logic        out_valid, overrun, busy;
  logic [3:0]  s_a, s_b, s_ab;
  logic        s_valid, s_overrun, s_busy;

  always #2 clk = ~clk;

  coincidence_counter dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .gate_len(gate_len), .window(window),
    .pulse_a(pulse_a), .pulse_b(pulse_b),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_ab(cnt_ab),
    .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .busy(busy)
  );

  coincidence_counter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .gate_len(gate_len), .window(window),
    .pulse_a(pulse_a), .pulse_b(pulse_b),
    .cnt_a(s_a), .cnt_b(s_b), .cnt_ab(s_ab),
    .out_valid(s_valid), .out_ready(out_ready),
    .overrun(s_overrun), .busy(s_busy)
  );

  typedef struct {
    int a;
    int b;
    int ab;
  } res_t;

  res_t exp_q[$];
  res_t e_m;
  int tests = 0;
  int fails = 0;
  int pops = 0;
  int last_a, last_b, last_ab, last4_a;

  bit m_busy, m_valid, m_ovr, m_pa, m_pb;
  int m_g, m_w, m_t, m_cyc;
  int m_ca, m_cb, m_cab;
  int m_pend_a, m_pend_b;

  bit ta[400];
  bit tbp[400];

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int sat4(int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic void m_reset();
    m_busy = 0; m_valid = 0; m_ovr = 0;
    m_pa = 0; m_pb = 0; m_t = 0;
    m_ca = 0; m_cb = 0; m_cab = 0;
    m_pend_a = -1; m_pend_b = -1;
    exp_q.delete();
  endfunction

  // Pending-edge times stand in for the window: a partner edge
  // at most W cycles later closes the pending one.
  function automatic void m_step(bit en, bit pa, bit pb,
                                 bit rdy);
    bit ea = pa && !m_pa;
    bit eb = pb && !m_pb;
    bit done = m_valid && rdy;
    bit load = 0;
    m_pa = pa;
    m_pb = pb;
    m_cyc++;
    if (!m_busy) begin
      if (en) begin
        m_busy = 1;
        m_g = (gate_len == 0) ? 1 : int'(gate_len);
        m_w = int'(window);
        m_ovr = 0; m_t = 0;
        m_ca = 0; m_cb = 0; m_cab = 0;
        m_pend_a = -1; m_pend_b = -1;
      end
    end else if (!en) begin
      m_busy = 0;
      m_pend_a = -1; m_pend_b = -1;
    end else begin
      if (ea) m_ca++;
      if (eb) m_cb++;
      if (ea && eb) begin
        m_cab++;
        m_pend_a = -1; m_pend_b = -1;
      end else if (eb) begin
        if (m_pend_a >= 0 && m_cyc - m_pend_a <= m_w) begin
          m_cab++;
          m_pend_a = -1;
        end else m_pend_b = m_cyc;
      end else if (ea) begin
        if (m_pend_b >= 0 && m_cyc - m_pend_b <= m_w) begin
          m_cab++;
          m_pend_b = -1;
        end else m_pend_a = m_cyc;
      end
      if (m_t == m_g - 1) begin
        if (!m_valid || rdy) begin
          exp_q.push_back('{m_ca, m_cb, m_cab});
          load = 1;
        end else m_ovr = 1;
        m_t = 0;
        m_ca = 0; m_cb = 0; m_cab = 0;
        m_pend_a = -1; m_pend_b = -1;
      end else m_t++;
    end
    if (load) m_valid = 1;
    else if (done) m_valid = 0;
  endfunction

  always @(negedge clk) begin
    check("out_valid", out_valid, m_valid);
    check("overrun", overrun, m_ovr);
    check("busy", busy, m_busy);
    check("out_valid4", s_valid, m_valid);
    check("overrun4", s_overrun, m_ovr);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got a=%0d b=%0d ab=%0d expected none",
                 cnt_a, cnt_b, cnt_ab);
      end else begin
        e_m = exp_q.pop_front();
        check("cnt_a", cnt_a, e_m.a);
        check("cnt_b", cnt_b, e_m.b);
        check("cnt_ab", cnt_ab, e_m.ab);
        check("cnt_a4", s_a, sat4(e_m.a));
        check("cnt_b4", s_b, sat4(e_m.b));
        check("cnt_ab4", s_ab, sat4(e_m.ab));
        last_a = int'(cnt_a);
        last_b = int'(cnt_b);
        last_ab = int'(cnt_ab);
        last4_a = int'(s_a);
        pops++;
      end
    end
  end

  task automatic step(bit en, bit pa, bit pb, bit rdy);
    enable = en;
    pulse_a = pa;
    pulse_b = pb;
    out_ready = rdy;
    @(posedge clk);
    if (rst_n) m_step(en, pa, pb, rdy);
    else m_reset();
    #1;
  endtask

  task automatic clear_tab();
    foreach (ta[i]) begin
      ta[i] = 0;
      tbp[i] = 0;
    end
  endtask

  task automatic play(int from, int to, bit rdy);
    for (int i = from; i <= to; i++)
      step(1, ta[i], tbp[i], rdy);
  endtask

  task automatic start(int g, int w);
    gate_len = GW'(g);
    window = WW'(w);
    step(1, 0, 0, 1);
  endtask

  task automatic stop_drain();
    repeat (5) step(0, 0, 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    m_reset();
    repeat (3) step(0, 0, 0, 1);
    rst_n = 1;
  endtask

  task automatic check_last(string n, int a, int b, int ab);
    check({n, "_a"}, last_a, a);
    check({n, "_b"}, last_b, b);
    check({n, "_ab"}, last_ab, ab);
  endtask

  task automatic check_idle_zero(string n);
    check({n, "_cnt_a"}, cnt_a, 0);
    check({n, "_cnt_b"}, cnt_b, 0);
    check({n, "_cnt_ab"}, cnt_ab, 0);
    check({n, "_valid"}, out_valid, 0);
    check({n, "_busy"}, busy, 0);
  endtask

  int p0;

  initial begin
    m_reset();
    m_cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst_n = 1;

    clear_tab();
    ta[10] = 1; ta[11] = 1; ta[40] = 1;
    tbp[13] = 1; tbp[60] = 1;
    start(100, 5);
    play(0, 99, 1);
    stop_drain();
    check_last("basic", 2, 2, 1);

    clear_tab();
    ta[5] = 1; tbp[5] = 1;
    ta[15] = 1; tbp[16] = 1;
    start(30, 0);
    play(0, 29, 1);
    stop_drain();
    check_last("win0", 2, 2, 1);

    clear_tab();
    ta[98] = 1; tbp[101] = 1;
    for (int i = 130; i < 150; i++) ta[i] = 1;
    start(100, 8);
    play(0, 109, 1);
    check_last("xper1", 1, 0, 0);
    play(110, 199, 1);
    stop_drain();
    check_last("xper2", 1, 1, 0);

    clear_tab();
    ta[3] = 1; tbp[25] = 1;
    start(20, 4);
    play(0, 44, 0);
    check("ovr_set", overrun, 1);
    check("ovr_held_a", cnt_a, 1);
    check("ovr_held_b", cnt_b, 0);
    play(45, 47, 1);
    check("ovr_valid_drop", out_valid, 0);
    stop_drain();
    check("ovr_sticky", overrun, 1);
    start(20, 4);
    check("ovr_cleared", overrun, 0);
    stop_drain();

    clear_tab();
    for (int k = 0; k < 20; k++) ta[2*k] = 1;
    ta[60] = 1; ta[70] = 1; ta[80] = 1;
    start(50, 0);
    play(0, 54, 1);
    check("sat4_a", last4_a, 15);
    check("sat_full_a", last_a, 20);
    play(55, 99, 1);
    stop_drain();
    check("sat4_restart", last4_a, 3);

    clear_tab();
    ta[10] = 1; tbp[12] = 1;
    start(100, 3);
    p0 = pops;
    play(0, 49, 1);
    stop_drain();
    check("abort_no_result", pops, p0);
    start(100, 3);
    play(0, 29, 1);
    do_reset();
    check_idle_zero("midreset");
    check("midreset_ovr", overrun, 0);
    repeat (5) step(0, 0, 0, 1);
    check("midreset_no_result", pops, p0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 400; i++) begin
        ta[i] = ($urandom_range(0, 99) < 35);
        tbp[i] = ($urandom_range(0, 99) < 35);
      end
      start(int'($urandom_range(0, 40)),
            int'($urandom_range(0, 12)));
      for (int i = 0; i < 300; i++)
        step(1, ta[i], tbp[i], $urandom_range(0, 9) < 7);
      stop_drain();
    end

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/coincidence_counter.md
Name: coincidence_counter

Overview:
- Consumes two shaped photon pulses from the pulse shaping stage (channel A, channel B) in the 500 MHz domain.
- Counts singles on each channel and A/B coincidences within a programmable window over a programmable gate period.
- Latches the three counts at each gate end and presents them to the readout stage through a valid/ready handshake.

Parameters:
CNT_W, 32, width of each count accumulator and output
GATE_W, 32, width of gate length (cycles per integration period)
WIN_W, 8, width of coincidence window length (cycles)

Ports:
clk  input  1  500 MHz system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  run counting; low aborts the current period
gate_len  input  GATE_W  cycles per period, sampled on entering RUN
window  input  WIN_W  coincidence window in cycles, sampled on entering RUN
pulse_a  input  1  shaped pulse, channel A (level, may span several cycles)
pulse_b  input  1  shaped pulse, channel B
cnt_a  output  CNT_W  latched singles count A
cnt_b  output  CNT_W  latched singles count B
cnt_ab  output  CNT_W  latched coincidence count
out_valid  output  1  latched counts available
out_ready  input  1  consumer accepts counts
overrun  output  1  sticky: a period result was dropped
busy  output  1  high in RUN

Behaviour:
- Reset (rst_n low, async): all outputs 0, state IDLE, accumulators/timers/edge registers 0.
- Edge detect: prev_x registered; edge_x = pulse_x & ~prev_x. One event per rising edge, one cycle latency from the pulse to the count.
- States:
  - IDLE: busy=0. When enable=1, go to RUN, sample gate_len and window, clear overrun, zero the gate counter and accumulators.
  - RUN: busy=1. enable=0 means go to IDLE next cycle; the partial period is discarded and out_valid/outputs are untouched.
- Gate: the counter runs 0..G-1, with G = gate_len, and gate_len=0 treated as 1. The cycle with count G-1 is the period-end cycle. Edges in that cycle are included in the latched result. The counter then wraps to 0 and the accumulators restart from 0 (continuous back-to-back periods, no dead cycle).
- Singles: acc_a increments on edge_a; acc_b increments on edge_b.
- Window timers:
  - edge_a with no coincidence loads win_a=window; edge_b loads win_b likewise.
  - Each timer decrements by 1 per cycle while nonzero.
- Coincidence, at most +1 per cycle:
  - edge_a & edge_b in the same cycle counts as a coincidence; neither timer is loaded and both are cleared.
  - edge_b while win_a>0 counts; win_a is cleared and win_b is not loaded.
  - edge_a while win_b>0 counts, symmetric to the case above.
  - Each edge participates in at most one coincidence.
- window=0 means only same-cycle coincidences count.
- Both timers are cleared at the period end; there are no cross-period coincidences.
- Arithmetic: all accumulators saturate at all-ones and never wrap. Saturation persists only until the period restart.
- Output latch at period end:
  - out_valid=0, or out_valid=1 with out_ready=1 in the same cycle: load cnt_a/b/ab with the final values (including same-cycle edges); out_valid=1 next cycle.
  - out_valid=1 with out_ready=0: keep old outputs, drop new result, set overrun=1.
- Handshake: out_valid clears the cycle after out_valid & out_ready, unless a new result is loaded then. Outputs stay stable while out_valid=1 and out_ready=0.
- Mid-operation reset: immediate return to the reset values; no partial result is emitted.

Decomposition:
- Shared package: state enum (IDLE, RUN); the WIN_W/GATE_W/CNT_W default constants, shared with the readout stage.
- Sub-module window_edge_timer, instantiated twice:
  - Contains the edge detect, window load/decrement/clear, and window-open flag.
  - Coincidence arbitration and the counters stay in the top.

Test Plan:
- Gate=100, window=5, A edges at cycles 10,40, B edges at 13,60 -> cnt_a=2, cnt_b=2, cnt_ab=1, out_valid after period end.
- Simultaneous A and B edges at the same cycle, window=0 -> cnt_ab=1; B 1 cycle after A with window=0 -> cnt_ab=0.
- A edge at cycle 98, B at cycle 101, gate=100, window=8 -> period1 cnt_ab=0; period2 cnt_b=1, cnt_ab=0. A pulse held high 20 cycles counts 1.
- Hold out_ready=0 across two period ends -> first result held unchanged, overrun=1; out_ready=1 -> out_valid drops; re-enable clears overrun.
- CNT_W=4, 20 A edges in one period -> cnt_a=15 (saturated), next period starts from 0.
- enable low at mid-period, and rst_n pulsed low during RUN -> no new out_valid. After reset, all outputs are 0 and busy=0.
